// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative RV32M multiply/divide (shift-add multiplier, restoring divider, sign fix-up)
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, COMPUTE, FIXUP} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [1:0] op;
   logic neg_q, neg_r, div_zero, a_neg, b_neg;
   logic [WIDTH-1:0] b, hi, lo, a_mag, b_mag, quo, rem;
   logic [WIDTH:0] sum, shifted, trial;
   logic [2*WIDTH-1:0] prod;
   always_comb begin
      a_neg = !MCycleOp[0] && Operand1[WIDTH-1];
      b_neg = !MCycleOp[0] && Operand2[WIDTH-1];
      a_mag = a_neg ? -Operand1 : Operand1;
      b_mag = b_neg ? -Operand2 : Operand2;
      sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      shifted = {hi, lo[WIDTH-1]};
      trial = shifted - {1'b0, b};
      prod = neg_q ? -{hi, lo} : {hi, lo};
      quo = div_zero ? '1 : (neg_q ? -lo : lo);
      rem = neg_r ? -hi : hi;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = Start ? COMPUTE : IDLE;
         COMPUTE: state_nx = (cnt == CW'(WIDTH-1)) ? FIXUP : COMPUTE;
         default: state_nx = IDLE;
      endcase
   end
   assign Busy = (state != IDLE);
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt <= '0;
         op <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div_zero <= 1'b0;
         b <= '0;
         hi <= '0;
         lo <= '0;
         Result1 <= '0;
         Result2 <= '0;
         Done <= 1'b0;
      end else begin
         Done <= (state == FIXUP);
         case (state)
            IDLE: if (Start) begin
               // mul: lo=multiplier, b=multiplicand; div: lo=dividend, b=divisor
               op <= MCycleOp;
               neg_q <= a_neg ^ b_neg;
               neg_r <= a_neg;
               div_zero <= (Operand2 == '0);
               b <= MCycleOp[1] ? b_mag : a_mag;
               lo <= MCycleOp[1] ? a_mag : b_mag;
               hi <= '0;
               cnt <= '0;
            end
            COMPUTE: begin
               cnt <= cnt + 1'b1;
               if (!op[1]) begin
                  hi <= sum[WIDTH:1];
                  lo <= {sum[0], lo[WIDTH-1:1]};
               end else begin
                  hi <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], ~trial[WIDTH]};
               end
            end
            FIXUP: begin
               Result1 <= op[1] ? quo : prod[WIDTH-1:0];
               Result2 <= op[1] ? rem : prod[2*WIDTH-1:WIDTH];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed checks of mcycle_unit against a cycle-level arithmetic model
module tb_mcycle_unit;
   logic        CLK = 0, RESETn = 0, Start = 0, Busy, Done;
   logic [1:0]  MCycleOp = 0;
   logic [31:0] Operand1 = 0, Operand2 = 0, Result1, Result2;
   int total = 0, bad = 0, cyc = 0, done_cyc = 0;

   mcycle_unit #(.WIDTH(32)) dut (
      .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
      .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1),
      .Result2(Result2), .Busy(Busy), .Done(Done)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {Result2, Result1} from RV32M arithmetic rules
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic signed [63:0] sp;
      sa = a;
      sb = b;
      case (op)
         2'b00: begin sp = 64'(sa) * 64'(sb); return sp; end
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      endcase
   endfunction

   int left = 0;
   logic exp_done = 0;
   logic [63:0] pend = 0, exp_res = 0;
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         left = 0;
         exp_done = 0;
         exp_res = 0;
      end else begin
         exp_done = 0;
         if (left == 0) begin
            if (Start) begin
               left = 33;
               pend = model(MCycleOp, Operand1, Operand2);
            end
         end else begin
            left--;
            if (left == 0) begin
               exp_done = 1;
               exp_res = pend;
            end
         end
      end
   end

   always @(negedge CLK) begin
      check("busy", 64'(Busy), 64'(left != 0));
      check("done", 64'(Done), 64'(exp_done));
      check("results", {Result2, Result1}, exp_res);
   end

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e1, input logic [31:0] e2, input bit poke);
      int n;
      Start = 1;
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      @(negedge CLK);
      Start = 0;
      Operand1 = 32'hDEAD_BEEF;
      Operand2 = 32'h0BAD_F00D;
      check({name, "_busy_next"}, 64'(Busy), 64'(1));
      n = 0;
      while (!Done && n < 40) begin
         if (poke && n == 5) begin
            Start = 1;
            MCycleOp = 2'b01;
            Operand1 = 32'h0000_1111;
            Operand2 = 32'h0000_2222;
         end else Start = 0;
         @(negedge CLK);
         n++;
      end
      Start = 0;
      done_cyc = cyc;
      check({name, "_latency"}, 64'(n), 64'(33));
      check({name, "_r1"}, 64'(Result1), 64'(e1));
      check({name, "_r2"}, 64'(Result2), 64'(e2));
   endtask

   task automatic idle(input int k);
      Start = 0;
      repeat (k) @(negedge CLK);
   endtask

   initial begin
      int t0;
      repeat (3) @(negedge CLK);
      check("reset_busy", 64'(Busy), 64'(0));
      check("reset_res", {Result2, Result1}, 64'(0));
      RESETn = 1;
      idle(2);
      run_op("smul_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 0); idle(1);
      run_op("umul", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'h0000_0004, 0); idle(1);
      run_op("smul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 0); idle(1);
      // abandon a signed mul after ten iterations
      Start = 1; MCycleOp = 2'b00; Operand1 = 7; Operand2 = 6;
      @(negedge CLK);
      Start = 0;
      repeat (10) @(negedge CLK);
      #2 RESETn = 0;
      #1 check("midreset_busy", 64'(Busy), 64'(0));
      check("midreset_done", 64'(Done), 64'(0));
      check("midreset_res", {Result2, Result1}, 64'(0));
      idle(2);
      RESETn = 1;
      idle(1);
      run_op("smul_after_reset", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 32'h0, 0); idle(1);
      run_op("sdiv", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0); idle(1);
      run_op("udiv", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 0); idle(1);
      run_op("sdiv_zero", 2'b10, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
      @(negedge CLK);
      check("dz_done_once", 64'(Done), 64'(0));
      run_op("sdiv_zero_neg", 2'b10, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 0); idle(1);
      run_op("udiv_zero", 2'b11, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 0); idle(1);
      run_op("sdiv_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0); idle(1);
      run_op("sdiv_min2", 2'b10, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 32'h0, 0); idle(1);
      run_op("udiv_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0); idle(1);
      run_op("poke_ignored", 2'b00, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFEE, 32'hFFFF_FFFF, 1); idle(1);
      // chained ops: each Start lands in the previous Done cycle
      run_op("chain0", 2'b11, 32'd1000, 32'd33, 32'd30, 32'd10, 0);
      t0 = done_cyc;
      run_op("chain1", 2'b10, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32'd6, 0);
      check("chain_gap1", 64'(done_cyc - t0), 64'(34));
      t0 = done_cyc;
      run_op("chain2", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 0);
      check("chain_gap2", 64'(done_cyc - t0), 64'(34));
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
